// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch and program-load bus of the k-series instruction memory.
//   master : core fetch stage + boot/debug loader (drives requests and beats)
//   slave  : prog_mem (returns instructions and load status)
// Signals:
//   fetch_en/fetch_addr -> inst/inst_valid   1-cycle registered fetch
//   ld_start/ld_valid/ld_data/ld_last        load control and beat stream
//   ld_ready/ld_done/ld_err/busy/prog_len    load status
// Handshake: a load beat transfers on a clk edge where ld_valid && ld_ready are
// both high. ld_ready may drop without notice (e.g. when ld_start is raised or
// the load finishes); the loader keeps ld_valid/ld_data/ld_last stable until
// the beat is accepted. inst_valid is a pure one-cycle response flag with no
// backpressure: the core must take inst whenever inst_valid is high.
interface prog_mem_if #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 8
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              ld_start;
  logic              ld_valid;
  logic [INST_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic              busy;
  logic [ADDR_W:0]   prog_len;

  modport master (
    output fetch_en, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
    input  inst, inst_valid, ld_ready, ld_done, ld_err, busy, prog_len
  );

  modport slave (
    input  fetch_en, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
    output inst, inst_valid, ld_ready, ld_done, ld_err, busy, prog_len
  );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: loadable instruction memory for the k-series core.
// Program words are streamed in over the load port of prog_mem_if; the core
// fetches them with a registered 1-cycle read. Addresses at or beyond the
// loaded program length (or any fetch while not in RUN) return IDLE_INST so the
// core idles safely past end-of-program.
// Ports:
//   clk        clock
//   reset_n    synchronous active-low reset
//   bus        prog_mem_if.slave (fetch + load signals)
//   fsm_state  debug view of the load FSM (0=EMPTY, 1=LOAD, 2=RUN)
// Optional build macro PROG_MEM_BOOT_EN: reset comes up in RUN serving a
// built-in 9-word boot program (Fibonacci) until the first ld_start.
module prog_mem #(
  parameter int                ADDR_W    = 4,
  parameter int                INST_W    = 8,
  parameter logic [INST_W-1:0] IDLE_INST = INST_W'(8'b00110000)
) (
  input  logic         clk,
  input  logic         reset_n,
  prog_mem_if.slave    bus,
  output logic [1:0]   fsm_state
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

`ifdef PROG_MEM_BOOT_EN
  localparam state_t          RESET_STATE = RUN;
  localparam logic [ADDR_W:0] RESET_LEN   = (ADDR_W+1)'(9);
`else
  localparam state_t          RESET_STATE = EMPTY;
  localparam logic [ADDR_W:0] RESET_LEN   = '0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   prog_len;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              ld_done;
  logic              ld_err;
  logic              ld_ready;
  logic              accept;
  logic              hit;
  logic [INST_W-1:0] rd_word;

  logic [INST_W-1:0] mem [DEPTH];

`ifdef PROG_MEM_BOOT_EN
  // Set by reset, cleared forever by the first ld_start.
  logic boot_mode;

  function automatic logic [INST_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
    logic [7:0] w;
    case (32'(a))
      0:       w = 8'h08;
      1:       w = 8'h19;
      2:       w = 8'h22;
      3:       w = 8'h10;
      4:       w = 8'h70;
      5:       w = 8'h00;
      6:       w = 8'h14;
      7:       w = 8'h04;
      8:       w = 8'hB2;
      default: w = 8'h30;
    endcase
    return INST_W'(w);
  endfunction
`endif

  // ld_start outranks a coincident beat, so ready is withdrawn in that cycle.
  assign ld_ready = (state == LOAD) && !bus.ld_start;
  assign accept   = bus.ld_valid && ld_ready;
  assign hit      = (state == RUN) && ({1'b0, bus.fetch_addr} < prog_len);

  always_comb begin
    rd_word = IDLE_INST;
    if (hit) begin
`ifdef PROG_MEM_BOOT_EN
      rd_word = boot_mode ? boot_word(bus.fetch_addr) : mem[bus.fetch_addr];
`else
      rd_word = mem[bus.fetch_addr];
`endif
    end
  end

  // Storage has no reset: contents past prog_len are never returned.
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      mem[wr_ptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RESET_STATE;
      wr_ptr     <= '0;
      prog_len   <= RESET_LEN;
      inst       <= IDLE_INST;
      inst_valid <= 1'b0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
`ifdef PROG_MEM_BOOT_EN
      boot_mode  <= 1'b1;
`endif
    end else begin
      ld_done    <= 1'b0;
      inst_valid <= bus.fetch_en;
      if (bus.fetch_en) begin
        inst <= rd_word;
      end

      if (bus.ld_start) begin
        state    <= LOAD;
        wr_ptr   <= '0;
        prog_len <= '0;
        ld_err   <= 1'b0;
`ifdef PROG_MEM_BOOT_EN
        boot_mode <= 1'b0;
`endif
      end else if (accept) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        // Computed from the pre-increment pointer so a full load reads DEPTH.
        prog_len <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
        if (bus.ld_last) begin
          state   <= RUN;
          ld_done <= 1'b1;
        end else if (&wr_ptr) begin
          // Memory full without an end marker: keep what fits, flag overrun.
          state   <= RUN;
          ld_done <= 1'b1;
          ld_err  <= 1'b1;
        end
      end
    end
  end

  assign bus.inst       = inst;
  assign bus.inst_valid = inst_valid;
  assign bus.ld_ready   = ld_ready;
  assign bus.ld_done    = ld_done;
  assign bus.ld_err     = ld_err;
  assign bus.busy       = (state == LOAD);
  assign bus.prog_len   = prog_len;
  assign fsm_state      = state;
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: self-checking bench for prog_mem (ADDR_W=4, INST_W=8).
// A reference model (program array, length and load/run flags) predicts every
// fetch result and load status; fetch predictions go into exp_q and a monitor
// pops them whenever the DUT shows inst_valid.
module tb_prog_mem;
  localparam int         ADDR_W = 4;
  localparam int         INST_W = 8;
  localparam int         DEPTH  = 16;
  localparam logic [7:0] IDLE   = 8'h30;

  logic       clk;
  logic       reset_n;
  logic [1:0] fsm_state;

  prog_mem_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  prog_mem #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [INST_W-1:0] exp_q[$];
  logic [INST_W-1:0] hold_exp;

  // ---------------- reference model ----------------
  logic [7:0] m_mem [DEPTH];
  int         m_len;
  int         m_ptr;
  bit         m_loading;
  bit         m_running;
  bit         m_err;
  bit         m_boot;
  logic [7:0] boot_tbl [9];

  initial begin
    boot_tbl[0] = 8'h08; boot_tbl[1] = 8'h19; boot_tbl[2] = 8'h22;
    boot_tbl[3] = 8'h10; boot_tbl[4] = 8'h70; boot_tbl[5] = 8'h00;
    boot_tbl[6] = 8'h14; boot_tbl[7] = 8'h04; boot_tbl[8] = 8'hB2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_fetch(input int addr);
    if (m_boot) return (addr < 9) ? boot_tbl[addr] : IDLE;
    if (m_running && addr < m_len) return m_mem[addr];
    return IDLE;
  endfunction

  task automatic model_reset();
`ifdef PROG_MEM_BOOT_EN
    m_boot    = 1'b1;
    m_running = 1'b1;
    m_len     = 9;
`else
    m_boot    = 1'b0;
    m_running = 1'b0;
    m_len     = 0;
`endif
    m_loading = 1'b0;
    m_ptr     = 0;
    m_err     = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      hold_exp = IDLE;
      check("reset_inst", bus.inst, IDLE);
      check("reset_inst_valid", bus.inst_valid, 1'b0);
    end else if (bus.inst_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst_valid", 1'b1, 1'b0);
      end else begin
        hold_exp = exp_q.pop_front();
        check("fetch_inst", bus.inst, hold_exp);
      end
    end else begin
      if (exp_q.size() != 0) begin
        check("missing_inst_valid", 1'b0, 1'b1);
        void'(exp_q.pop_front());
      end
      check("inst_hold", bus.inst, hold_exp);
    end
  end

  // ---------------- driver ----------------
  // One clock cycle of stimulus: inputs applied at negedge, status checked
  // just after the following posedge.
  task automatic cycle(input bit fe, input int fa, input bit ls, input bit lv,
                       input logic [7:0] ld, input bit ll);
    bit exp_ready;
    bit exp_done;
    @(negedge clk);
    bus.fetch_en   = fe;
    bus.fetch_addr = 4'(fa);
    bus.ld_start   = ls;
    bus.ld_valid   = lv;
    bus.ld_data    = ld;
    bus.ld_last    = ll;
    if (fe) exp_q.push_back(m_loading ? IDLE : model_fetch(fa));
    exp_ready = m_loading && !ls;
    #1;
    check("ld_ready", bus.ld_ready, exp_ready);
    @(posedge clk);
    exp_done = 1'b0;
    if (ls) begin
      m_loading = 1'b1; m_running = 1'b0; m_boot = 1'b0;
      m_ptr = 0; m_len = 0; m_err = 1'b0;
    end else if (m_loading && lv) begin
      m_mem[m_ptr] = ld;
      m_ptr++;
      m_len = m_ptr;
      if (ll || m_ptr == DEPTH) begin
        m_loading = 1'b0; m_running = 1'b1; exp_done = 1'b1;
        if (!ll) m_err = 1'b1;
      end
    end
    #1;
    check("ld_done", bus.ld_done, exp_done);
    check("ld_err", bus.ld_err, m_err);
    check("prog_len", bus.prog_len, m_len);
    check("busy", bus.busy, m_loading);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic fetch(input int a);
    cycle(1, a, 0, 0, 8'h00, 0);
  endtask

  task automatic beat(input logic [7:0] d, input bit last);
    cycle(0, 0, 0, 1, d, last);
  endtask

  task automatic start();
    cycle(0, 0, 1, 0, 8'h00, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.ld_start   = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_last    = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("reset_prog_len", bus.prog_len, m_len);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_ld_err", bus.ld_err, 1'b0);
    check("reset_ld_done", bus.ld_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_start   = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    hold_exp       = IDLE;
    model_reset();

    do_reset();
    for (int i = 0; i < 4; i++) fetch(i);
`ifdef PROG_MEM_BOOT_EN
    fetch(8);
    fetch(9);
`endif
    idle();

    // Short program with end marker.
    start();
    beat(8'hA1, 0); beat(8'hB2, 0); beat(8'hC3, 1);
    for (int i = 0; i < 4; i++) fetch(i);
`ifdef PROG_MEM_BOOT_EN
    start();
    beat(8'h55, 1);
    fetch(0);
    fetch(1);
`endif

    // Full load without end marker, then an extra beat that must be ignored.
    start();
    for (int i = 0; i < DEPTH; i++) beat(8'(i), 0);
    beat(8'hEE, 0);
    fetch(15); fetch(0); fetch(7);

    // Restart mid-load with a coincident beat.
    start();
    for (int i = 0; i < 5; i++) beat(8'h40 + 8'(i), 0);
    fetch(0);
    cycle(0, 0, 1, 1, 8'h99, 0);
    beat(8'h61, 0); beat(8'h62, 1);
    fetch(4); fetch(0); fetch(1); fetch(2);

    // Gaps in the beat stream.
    start();
    beat(8'hD0, 0); idle(); beat(8'hD1, 0); idle();
    beat(8'hD2, 1);
    fetch(0); fetch(1); fetch(2); fetch(3);

    // Reset in the middle of a load.
    start();
    beat(8'h11, 0); beat(8'h22, 0);
    do_reset();
    fetch(0); fetch(1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
            8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
    end

    idle(); idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Parametrised, loadable instruction memory for the k-series core; the next generation after the fixed 16x8 combinational program ROM.
- Program words are streamed in over a valid/ready load port. The core fetches them with a registered 1-cycle read.
- Any address at or beyond the loaded program length returns the idle instruction, so the core idles safely past end-of-program.
- Sits between the debug/boot loader and the core fetch stage.

Parameters:
- ADDR_W, 4, fetch/load address width; DEPTH = 2**ADDR_W words.
- INST_W, 8, instruction width in bits.
- IDLE_INST, 8'b00110000 (zero-extended to INST_W), word returned for unloaded addresses, during load, and after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- fetch_en  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  fetch address.
- inst  out  INST_W  fetched instruction, registered.
- inst_valid  out  1  inst holds the response to the previous cycle's fetch_en.
- ld_start  in  1  begin/restart a program load (single-cycle pulse).
- ld_valid  in  1  load beat valid.
- ld_data  in  INST_W  load beat payload.
- ld_last  in  1  marks the final beat of the program.
- ld_ready  out  1  combinational; equals (state==LOAD) && !ld_start.
- ld_done  out  1  one-cycle pulse on LOAD->RUN.
- ld_err  out  1  sticky; set when DEPTH beats are accepted without ld_last. Cleared by ld_start or reset.
- busy  out  1  high while state==LOAD.
- prog_len  out  ADDR_W+1  number of valid words loaded (0..DEPTH).

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge):
  - state=EMPTY, wr_ptr=0, prog_len=0.
  - inst=IDLE_INST; inst_valid, ld_done, ld_err = 0.
  - Memory array is not cleared; it is unreachable because prog_len=0.
  - Reset asserted mid-load aborts the load. Beats already written are discarded (prog_len=0).
- States:
  - EMPTY: no program.
  - LOAD: accepting beats.
  - RUN: program valid.
- Transitions:
  - EMPTY/RUN/LOAD + ld_start -> LOAD; wr_ptr=0, prog_len=0, ld_err=0. ld_start always wins, including mid-load (restart).
  - LOAD + accepted beat with ld_last=1 -> RUN, ld_done=1 for one cycle.
  - LOAD + accepted beat at wr_ptr==DEPTH-1 with ld_last=0 -> RUN, ld_done=1, ld_err=1.
- Accepted beat (ld_valid && ld_ready):
  - mem[wr_ptr] <= ld_data.
  - wr_ptr increments, wrapping from DEPTH-1 to 0.
  - prog_len <= wr_ptr+1.
  - prog_len reaches DEPTH exactly on a full load; it never wraps.
- ld_valid while ld_ready=0: beat ignored, no state change. The upstream loader must hold it.
- Fetch:
  - fetch_en at edge N gives inst/inst_valid at edge N+1. Latency is 1 cycle; one fetch per cycle, fully pipelined.
  - inst = mem[fetch_addr] only if state==RUN and fetch_addr < prog_len. Otherwise inst = IDLE_INST.
  - fetch_en=0: inst_valid=0; inst holds its last value.
  - Fetch during LOAD returns IDLE_INST with inst_valid=1. There is no read/write hazard.
- Simultaneous ld_start and ld_valid: ld_ready=0, so the beat is not accepted and the restart takes effect.
- Memory is inferred as a single synchronous-read, single-write RAM.

Optional Feature:
- Macro: PROG_MEM_BOOT_EN.
- Defined:
  - Reset leaves state=RUN and prog_len=9.
  - A built-in boot table (the Fibonacci program) is served for addresses 0..8, zero-extended to INST_W: 08,19,22,10,70,00,14,04,B2 (hex).
  - The first ld_start permanently switches fetches to the RAM path until the next reset.
- Not defined: reset leaves state=EMPTY as above; there is no boot table.

Test Plan:
- Reset, then fetch addr 0..3 -> inst=8'h30 every cycle, inst_valid=1 one cycle after each fetch_en, prog_len=0, busy=0.
- ld_start; stream 8'hA1,8'hB2,8'hC3 with ld_last on C3 -> ld_done pulses once, prog_len=3. Fetch 0,1,2,3 -> A1,B2,C3,30.
- Full load: 16 beats 8'h00..8'h0F, no ld_last -> state RUN, ld_err=1, prog_len=16. Fetch 15 -> 8'h0F. A 17th ld_valid is ignored (ld_ready=0).
- Mid-load restart: 5 beats, then ld_start coincident with ld_valid -> that beat is not accepted, prog_len=0. A new 2-beat load gives prog_len=2 and fetch 4 -> 8'h30.
- Backpressure/gaps: ld_valid toggles 1,0,1,0 across 4 cycles -> exactly 2 words written, in order.
- PROG_MEM_BOOT_EN: reset, fetch 0 -> 8'h08, fetch 8 -> 8'hB2, fetch 9 -> 8'h30. After ld_start plus a 1-beat load of 8'h55, fetch 0 -> 8'h55.
